// File: rtl/guess_entry_ctrl_pkg.sv
// Shared types and helpers for the guess-entry controller.
package guess_entry_ctrl_pkg;

    // Compare sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMP  = 2'd1,
        ST_DONE = 2'd2
    } cmp_state_t;

    localparam int GUESS_COUNT_W = 8;

    // Bits needed to hold the values 0..n-1 (never less than one bit)
    function automatic int count_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/guess_entry_ctrl_digit_bank.sv
// N_DIGITS x DIGIT_W digit register file with a single indexed write port.
module digit_bank
    import guess_entry_ctrl_pkg::*;
#(
    parameter  int N_DIGITS = 4,
    parameter  int DIGIT_W  = 4,
    localparam int AW       = count_w(N_DIGITS)
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        we,
    input  logic [AW-1:0]               waddr,
    input  logic [DIGIT_W-1:0]          wdata,
    output logic [N_DIGITS*DIGIT_W-1:0] data_flat
);

    // Write the addressed digit; all other digits hold
    always_ff @(posedge clock) begin
        if (reset) begin
            data_flat <= '0;
        end else if (we) begin
            for (int k = 0; k < N_DIGITS; k++) begin
                if (waddr == AW'(k)) begin
                    data_flat[k*DIGIT_W +: DIGIT_W] <= wdata;
                end
            end
        end
    end

endmodule

// File: rtl/guess_entry_ctrl.sv
// Code-breaker entry controller: keypad entry into secret/guess banks and a
// sequential one-position-per-cycle scorer producing exact (A) and
// misplaced (B) hit counts.
//
//   state   | meaning
//   IDLE    | waiting for a submit rising edge; entry allowed
//   CMP     | scoring guess position idx, one per cycle
//   DONE    | load counts, bump guess counter, update win
module guess_entry_ctrl
    import guess_entry_ctrl_pkg::*;
#(
    parameter  int N_DIGITS = 4,
    parameter  int DIGIT_W  = 4,
    parameter  int BASE     = 10,
    localparam int CUR_W    = count_w(N_DIGITS),
    localparam int CNT_W    = count_w(N_DIGITS + 1)
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        mode,
    input  logic                        key_valid,
    input  logic [DIGIT_W-1:0]          key_code,
    input  logic [N_DIGITS-1:0]         digit_sel_n,
    input  logic                        submit,
    output logic [CUR_W-1:0]            cursor,
    output logic [N_DIGITS*DIGIT_W-1:0] secret_flat,
    output logic [N_DIGITS*DIGIT_W-1:0] guess_flat,
    output logic                        busy,
    output logic                        result_valid,
    output logic [CNT_W-1:0]            a_count,
    output logic [CNT_W-1:0]            b_count,
    output logic                        win,
    output logic [GUESS_COUNT_W-1:0]    guess_count
);

    localparam logic [DIGIT_W:0]   BASE_L   = (DIGIT_W + 1)'(BASE);
    localparam logic [CUR_W-1:0]   LAST_POS = CUR_W'(N_DIGITS - 1);
    localparam logic [CNT_W-1:0]   FULL_HIT = CNT_W'(N_DIGITS);

    cmp_state_t         state, state_next;
    logic [CUR_W-1:0]   idx, idx_next, sel_idx, wr_pos;
    logic [CNT_W-1:0]   acc_a, acc_b, acc_a_next, acc_b_next;
    logic               submit_q, submit_edge, sel_any, key_ok;
    logic               wr_en, wr_secret, wr_guess, load_result;
    logic [DIGIT_W-1:0] g_dig, s_dig;
    logic               pos_hit, pos_mis;

    assign busy        = (state != ST_IDLE);
    assign submit_edge = submit & ~submit_q;
    assign sel_any     = ~&digit_sel_n;
    assign key_ok      = key_valid && ({1'b0, key_code} < BASE_L);
    assign wr_en       = key_ok && !busy;
    assign wr_secret   = wr_en && !mode;
    assign wr_guess    = wr_en && mode;

    // Highest-index pressed select button wins
    always_comb begin
        sel_idx = '0;
        for (int k = 0; k < N_DIGITS; k++) begin
            if (!digit_sel_n[k]) sel_idx = CUR_W'(k);
        end
    end

    // A select on the same edge as a key redirects that key's write
    assign wr_pos = sel_any ? sel_idx : cursor;

    // Cursor: follows selects, advances with wrap after each accepted key
    always_ff @(posedge clock) begin
        if (reset) begin
            cursor <= '0;
        end else if (!busy) begin
            if (key_ok) begin
                cursor <= (wr_pos == LAST_POS) ? '0 : wr_pos + 1'b1;
            end else if (sel_any) begin
                cursor <= sel_idx;
            end
        end
    end

    digit_bank #(.N_DIGITS(N_DIGITS), .DIGIT_W(DIGIT_W)) u_secret (
        .clock     (clock),
        .reset     (reset),
        .we        (wr_secret),
        .waddr     (wr_pos),
        .wdata     (key_code),
        .data_flat (secret_flat)
    );

    digit_bank #(.N_DIGITS(N_DIGITS), .DIGIT_W(DIGIT_W)) u_guess (
        .clock     (clock),
        .reset     (reset),
        .we        (wr_guess),
        .waddr     (wr_pos),
        .wdata     (key_code),
        .data_flat (guess_flat)
    );

    // Score guess position idx: exact hit, else any other secret digit matches
    always_comb begin
        g_dig   = '0;
        s_dig   = '0;
        pos_mis = 1'b0;
        for (int k = 0; k < N_DIGITS; k++) begin
            if (idx == CUR_W'(k)) begin
                g_dig = guess_flat[k*DIGIT_W +: DIGIT_W];
                s_dig = secret_flat[k*DIGIT_W +: DIGIT_W];
            end
        end
        for (int j = 0; j < N_DIGITS; j++) begin
            if ((idx != CUR_W'(j)) && (secret_flat[j*DIGIT_W +: DIGIT_W] == g_dig)) begin
                pos_mis = 1'b1;
            end
        end
        pos_hit = (g_dig == s_dig);
    end

    // Compare sequencer next-state and accumulator updates
    always_comb begin
        state_next  = state;
        idx_next    = idx;
        acc_a_next  = acc_a;
        acc_b_next  = acc_b;
        load_result = 1'b0;
        case (state)
            ST_IDLE: begin
                if (submit_edge) begin
                    state_next = ST_CMP;
                    idx_next   = '0;
                    acc_a_next = '0;
                    acc_b_next = '0;
                end
            end
            ST_CMP: begin
                if (pos_hit) begin
                    acc_a_next = acc_a + 1'b1;
                end else if (pos_mis) begin
                    acc_b_next = acc_b + 1'b1;
                end
                idx_next = idx + 1'b1;
                if (idx == LAST_POS) state_next = ST_DONE;
            end
            ST_DONE: begin
                state_next  = ST_IDLE;
                load_result = 1'b1;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Sequencer registers; submit history resets high so a held submit is not an edge
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= ST_IDLE;
            idx      <= '0;
            acc_a    <= '0;
            acc_b    <= '0;
            submit_q <= 1'b1;
        end else begin
            state    <= state_next;
            idx      <= idx_next;
            acc_a    <= acc_a_next;
            acc_b    <= acc_b_next;
            submit_q <= submit;
        end
    end

    // Result registers: counts, pulse, saturating guess counter, sticky win
    always_ff @(posedge clock) begin
        if (reset) begin
            result_valid <= 1'b0;
            a_count      <= '0;
            b_count      <= '0;
            guess_count  <= '0;
            win          <= 1'b0;
        end else begin
            result_valid <= load_result;
            if (load_result) begin
                a_count <= acc_a;
                b_count <= acc_b;
                if (guess_count != '1) guess_count <= guess_count + 1'b1;
                if (acc_a == FULL_HIT) win <= 1'b1;
            end else if (wr_secret) begin
                win <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_guess_entry_ctrl.sv
// Directed bench for guess_entry_ctrl (N_DIGITS=4, DIGIT_W=4, BASE=10).
module tb_guess_entry_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        mode = 1'b0;
    logic        key_valid = 1'b0;
    logic [3:0]  key_code = 4'd0;
    logic [3:0]  digit_sel_n = 4'hF;
    logic        submit = 1'b0;
    logic [1:0]  cursor;
    logic [15:0] secret_flat, guess_flat;
    logic        busy, result_valid, win;
    logic [2:0]  a_count, b_count;
    logic [7:0]  guess_count;

    int n_tests = 0;
    int n_fail  = 0;

    guess_entry_ctrl #(.N_DIGITS(4), .DIGIT_W(4), .BASE(10)) dut (
        .clock        (clock),
        .reset        (reset),
        .mode         (mode),
        .key_valid    (key_valid),
        .key_code     (key_code),
        .digit_sel_n  (digit_sel_n),
        .submit       (submit),
        .cursor       (cursor),
        .secret_flat  (secret_flat),
        .guess_flat   (guess_flat),
        .busy         (busy),
        .result_valid (result_valid),
        .a_count      (a_count),
        .b_count      (b_count),
        .win          (win),
        .guess_count  (guess_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        mode;
        logic        kv;
        logic [3:0]  code;
        logic [3:0]  sel;
        logic [1:0]  exp_cur;
        logic [15:0] exp_sec;
        logic [15:0] exp_gue;
    } vec_t;

    vec_t vecs[14];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_cursor"}, cursor, 0);
        chk({tag, "_secret"}, secret_flat, 0);
        chk({tag, "_guess"},  guess_flat, 0);
        chk({tag, "_busy"},   busy, 0);
        chk({tag, "_rv"},     result_valid, 0);
        chk({tag, "_a"},      a_count, 0);
        chk({tag, "_b"},      b_count, 0);
        chk({tag, "_gc"},     guess_count, 0);
        chk({tag, "_win"},    win, 0);
    endtask

    // Select position 0 on the first key, then let the cursor auto-advance
    task automatic load_bank(input logic m, input logic [3:0] d0, d1, d2, d3);
        mode = m; key_valid = 1'b1;
        digit_sel_n = 4'b1110; key_code = d0; tick();
        digit_sel_n = 4'hF;    key_code = d1; tick();
        key_code = d2; tick();
        key_code = d3; tick();
        key_valid = 1'b0;
    endtask

    task automatic wait_result(output int cyc);
        cyc = 0;
        while (cyc < 20) begin
            tick();
            cyc++;
            if (result_valid) return;
        end
        cyc = -1;
    endtask

    task automatic quiet_window(input int n, output int hits);
        hits = 0;
        for (int c = 0; c < n; c++) begin
            tick();
            if (busy || result_valid) hits++;
        end
    endtask

    task automatic do_compare(input string tag, input int ea, eb, egc, ewin);
        int cyc;
        submit = 1'b1;
        tick();
        chk({tag, "_busy"}, busy, 1);
        wait_result(cyc);
        chk({tag, "_latency"}, cyc, 5);
        chk({tag, "_a"},   a_count, ea);
        chk({tag, "_b"},   b_count, eb);
        chk({tag, "_gc"},  guess_count, egc);
        chk({tag, "_win"}, win, ewin);
        tick();
        chk({tag, "_pulse"}, result_valid, 0);
        submit = 1'b0;
        tick();
    endtask

    initial begin
        int cyc, hits;

        vecs[0]  = '{1'b0, 1'b1, 4'd1,  4'hF,    2'd1, 16'h0001, 16'h0000};
        vecs[1]  = '{1'b0, 1'b1, 4'd2,  4'hF,    2'd2, 16'h0021, 16'h0000};
        vecs[2]  = '{1'b0, 1'b1, 4'd3,  4'hF,    2'd3, 16'h0321, 16'h0000};
        vecs[3]  = '{1'b0, 1'b1, 4'd4,  4'hF,    2'd0, 16'h4321, 16'h0000};
        vecs[4]  = '{1'b0, 1'b1, 4'd11, 4'hF,    2'd0, 16'h4321, 16'h0000};
        vecs[5]  = '{1'b0, 1'b1, 4'd7,  4'b1011, 2'd3, 16'h4721, 16'h0000};
        vecs[6]  = '{1'b0, 1'b0, 4'd0,  4'b1110, 2'd0, 16'h4721, 16'h0000};
        vecs[7]  = '{1'b1, 1'b1, 4'd5,  4'hF,    2'd1, 16'h4721, 16'h0005};
        vecs[8]  = '{1'b1, 1'b1, 4'd9,  4'b0111, 2'd0, 16'h4721, 16'h9005};
        vecs[9]  = '{1'b1, 1'b1, 4'd10, 4'hF,    2'd0, 16'h4721, 16'h9005};
        vecs[10] = '{1'b1, 1'b1, 4'd15, 4'hF,    2'd0, 16'h4721, 16'h9005};
        vecs[11] = '{1'b0, 1'b0, 4'd0,  4'b0110, 2'd3, 16'h4721, 16'h9005};
        vecs[12] = '{1'b1, 1'b0, 4'd0,  4'hF,    2'd3, 16'h4721, 16'h9005};
        vecs[13] = '{1'b0, 1'b1, 4'd0,  4'hF,    2'd0, 16'h0721, 16'h9005};

        tick();
        tick();
        chk_reset_state("reset");
        reset = 1'b0;

        for (int i = 0; i < 14; i++) begin
            mode = vecs[i].mode; key_valid = vecs[i].kv;
            key_code = vecs[i].code; digit_sel_n = vecs[i].sel;
            tick();
            chk($sformatf("vec%0d_cursor", i), cursor, vecs[i].exp_cur);
            chk($sformatf("vec%0d_secret", i), secret_flat, vecs[i].exp_sec);
            chk($sformatf("vec%0d_guess", i),  guess_flat, vecs[i].exp_gue);
        end
        key_valid = 1'b0; digit_sel_n = 4'hF;
        tick();

        // Partial score: secret 1234, guess 1243
        load_bank(1'b0, 4'd1, 4'd2, 4'd3, 4'd4);
        load_bank(1'b1, 4'd1, 4'd2, 4'd4, 4'd3);
        chk("load_secret", secret_flat, 16'h4321);
        chk("load_guess",  guess_flat,  16'h3421);
        do_compare("partial", 2, 2, 1, 0);

        // Duplicates, then full hit
        load_bank(1'b1, 4'd1, 4'd1, 4'd1, 4'd1);
        do_compare("dups", 1, 3, 2, 0);
        load_bank(1'b1, 4'd1, 4'd2, 4'd3, 4'd4);
        do_compare("winner", 4, 0, 3, 1);

        // Win survives guess writes and rejected keys, clears on a secret write
        mode = 1'b1; key_valid = 1'b1; key_code = 4'd1; tick();
        chk("win_guess_wr", win, 1);
        mode = 1'b0; key_code = 4'd12; tick();
        chk("win_reject", win, 1);
        key_code = 4'd2; tick();
        chk("win_clear", win, 0);
        chk("win_clear_secret", secret_flat, 16'h4321);
        chk("win_clear_cursor", cursor, 2);
        key_valid = 1'b0;
        tick();

        // Lockout: key and select during busy ignored; re-submit edge dropped
        submit = 1'b1; tick();
        mode = 1'b1; key_valid = 1'b1; key_code = 4'd7; digit_sel_n = 4'b1101;
        submit = 1'b0; tick();
        chk("lock_guess", guess_flat, 16'h4321);
        chk("lock_cursor", cursor, 2);
        key_valid = 1'b0; digit_sel_n = 4'hF; submit = 1'b1; tick();
        wait_result(cyc);
        chk("lock_latency", cyc, 3);
        chk("lock_a", a_count, 4);
        chk("lock_gc", guess_count, 4);
        chk("lock_win", win, 1);
        quiet_window(10, hits);
        chk("lock_no_second", hits, 0);
        chk("lock_gc_after", guess_count, 4);
        submit = 1'b0; tick();

        // Reset mid-compare aborts with no result
        submit = 1'b1; tick(); tick(); tick();
        chk("abort_busy", busy, 1);
        reset = 1'b1; tick();
        reset = 1'b0;
        chk_reset_state("abort");
        quiet_window(8, hits);
        chk("abort_quiet", hits, 0);
        submit = 1'b0; tick();

        // Submit rising together with reset and held high: never a compare
        reset = 1'b1; submit = 1'b1; tick(); tick();
        reset = 1'b0;
        quiet_window(10, hits);
        chk("held_submit_quiet", hits, 0);
        chk("held_submit_gc", guess_count, 0);
        submit = 1'b0; tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
